// File: rtl/run_sequencer_if.sv
// Start/ack handshake and core-control bundle between the bench-side launcher and run_sequencer.
// The master drives start and done_in; the slave (the sequencer) drives all core controls and status.
interface run_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             done_in;
  logic             core_run;
  logic             core_clear;
  logic             ack;
  logic             timeout;
  logic             busy;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, done_in,
    input  core_run, core_clear, ack, timeout, busy, cycle_count
  );

  modport slave (
    input  start, done_in,
    output core_run, core_clear, ack, timeout, busy, cycle_count
  );
endinterface

// File: rtl/run_sequencer.sv
// Run controller for the accumulator core: start/ack handshake, core clear, run enable,
// DONE detection and watchdog. All outputs are decoded from flops only.
module run_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16,
  parameter int CLEAR_CYCLES   = 2
) (
  input logic           clk,
  input logic           reset,
  run_sequencer_if.slave sif
);

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             timeout_q, timeout_d;

  // done_in is only examined in RUN, so an undriven decoder elsewhere cannot disturb the state.
  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (sif.start) begin
          state_d       = S_HOLD;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
        end
      end
      S_HOLD: begin
        clr_cnt_d = '0;
        if (!sif.start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (sif.start) begin
          state_d = S_HOLD;
        end else if (clr_cnt_q == CLR_LAST) begin
          state_d = S_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // Restart beats DONE, and DONE beats the watchdog when both land on the same edge.
        if (sif.start) begin
          state_d       = S_HOLD;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
        end else begin
          cycle_count_d = cycle_count_q + 1'b1;
          if (sif.done_in) begin
            state_d = S_DONE;
          end else if (cycle_count_q == TMO_LAST) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (sif.start) begin
          state_d       = S_HOLD;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      clr_cnt_q     <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
    end
  end

  assign sif.core_run    = (state_q == S_RUN);
  assign sif.core_clear  = (state_q == S_HOLD) || (state_q == S_CLEAR);
  assign sif.busy        = (state_q == S_HOLD) || (state_q == S_CLEAR) || (state_q == S_RUN);
  assign sif.ack         = (state_q == S_DONE);
  assign sif.timeout     = timeout_q;
  assign sif.cycle_count = cycle_count_q;

endmodule
